// File: rtl/alu_pkg.sv
// Shared constants and helpers for the 8-bit ALU datapath.
// The result distributor and its select decoder both import this package.
package alu_pkg;

  localparam int WIDTH   = 8;
  localparam int NUM_OUT = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dist_state_t;

  function automatic logic [7:0] onehot8(input logic [2:0] sel);
    onehot8 = 8'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_1to8_dist_if.sv
// Upstream word port plus per-sink valid/ready bus of the result distributor.
// The distributor binds to the slave view; the producer/sink side uses master.
interface demux_1to8_dist_if #(
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int NUM_OUT = alu_pkg::NUM_OUT,
  parameter int CNT_W   = alu_pkg::CNT_W
);
  logic                      in_valid;
  logic                      in_ready;
  logic [alu_pkg::SEL_W-1:0] in_sel;
  logic                      in_bcast;
  logic [WIDTH-1:0]          in_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      busy;
  logic [CNT_W-1:0]          xfer_cnt;

  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, xfer_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, xfer_cnt
  );
endinterface

// File: rtl/demux_1to8_dist_decoder_3to8.sv
// Combinational one-hot decoder of the destination select with enable.
// A disabled decoder yields an all-zero mask; broadcast is merged by the parent.
module decoder_3to8
  import alu_pkg::*;
(
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);

  assign onehot = en ? onehot8(sel) : '0;

endmodule

// File: rtl/demux_1to8_dist.sv
// Registered 1-to-8 result distributor: holds one word and hands it to the
// selected sink(s) with per-sink valid/ready, counting fully delivered words.
module demux_1to8_dist #(
  parameter int WIDTH   = alu_pkg::WIDTH,
  parameter int NUM_OUT = alu_pkg::NUM_OUT,
  parameter int CNT_W   = alu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  demux_1to8_dist_if.slave  bus
);
  import alu_pkg::*;

  dist_state_t        state_reg, state_next;
  logic [NUM_OUT-1:0] pending_reg, pending_next;
  logic [NUM_OUT-1:0] remain;
  logic [NUM_OUT-1:0] sel_mask;
  logic [NUM_OUT-1:0] dest_mask;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               in_ready;
  logic               accept;
  logic               drain_done;

  // A sink's bit survives the edge only if it is still pending and not ready.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_remain
      assign remain[gi] = pending_reg[gi] & ~bus.out_ready[gi];
    end
  endgenerate

  decoder_3to8 u_decoder (
    .en     (~bus.in_bcast),
    .sel    (bus.in_sel),
    .onehot (sel_mask)
  );

  assign dest_mask  = sel_mask | {NUM_OUT{bus.in_bcast}};
  assign in_ready   = (pending_reg == '0) | (remain == '0);
  assign accept     = bus.in_valid & in_ready;
  assign drain_done = (pending_reg != '0) & (remain == '0);

  always_comb begin
    pending_next = remain;
    data_next    = data_reg;
    cnt_next     = cnt_reg;
    state_next   = state_reg;
    // Old word finishing and new word loading can share the same edge.
    if (drain_done) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
    if (accept) begin
      pending_next = dest_mask;
      data_next    = bus.in_data;
    end
    state_next = (pending_next != '0) ? HOLD : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      data_reg    <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      data_reg    <= data_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = pending_reg;
  assign bus.out_data  = data_reg;
  assign bus.busy      = (state_reg == HOLD);
  assign bus.xfer_cnt  = cnt_reg;

endmodule

// File: tb/tb_demux_1to8_dist.sv
// Directed plus randomized bench for demux_1to8_dist against a per-sink
// delivery model; a narrow-counter instance exercises counter wrap cheaply.
module tb_demux_1to8_dist;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demux_1to8_dist_if #(.WIDTH(8), .NUM_OUT(8), .CNT_W(16)) bus ();
  demux_1to8_dist_if #(.WIDTH(8), .NUM_OUT(8), .CNT_W(4))  bus_w ();

  demux_1to8_dist #(.WIDTH(8), .NUM_OUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  demux_1to8_dist #(.WIDTH(8), .NUM_OUT(8), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .bus(bus_w.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: which sinks still owe an acknowledgement for the held word.
  bit          m_owed[8];
  logic [7:0]  m_data;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_owed[i] = 1'b0;
    m_data = 8'h00;
    m_cnt  = 16'h0000;
  endtask

  function automatic logic [7:0] m_mask();
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) if (m_owed[i]) m = m | (8'(1) << i);
    return m;
  endfunction

  function automatic bit m_any_owed();
    for (int i = 0; i < 8; i++) if (m_owed[i]) return 1'b1;
    return 1'b0;
  endfunction

  // A new word fits once every sink still owed the old one is ready now.
  function automatic bit m_can_take(input logic [7:0] rdy);
    for (int i = 0; i < 8; i++) if (m_owed[i] && !rdy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input bit v, input int sel, input bit bc, input logic [7:0] d,
                       input logic [7:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = 3'(sel);
    bus.in_bcast  = bc;
    bus.in_data   = d;
    bus.out_ready = rdy;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_mask()));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, ".busy"},      32'(bus.busy),      32'(m_any_owed()));
    chk({tag, ".xfer_cnt"},  32'(bus.xfer_cnt),  32'(m_cnt));
  endtask

  // One clock: check in_ready before the edge, advance model, check outputs.
  task automatic cycle(input string tag);
    bit         v, bc, acc, had_word;
    logic [2:0] sel;
    logic [7:0] d, rdy;
    #1;
    v = bus.in_valid; bc = bus.in_bcast; sel = bus.in_sel; d = bus.in_data;
    rdy = bus.out_ready;
    acc = v && m_can_take(rdy);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_can_take(rdy)));
    @(posedge clk);
    had_word = m_any_owed();
    for (int i = 0; i < 8; i++) if (m_owed[i] && rdy[i]) m_owed[i] = 1'b0;
    if (had_word && !m_any_owed()) m_cnt = m_cnt + 16'd1;
    if (acc) begin
      for (int i = 0; i < 8; i++) m_owed[i] = bc || (i == int'(sel));
      m_data = d;
    end
    #1;
    check_outputs(tag);
    $display("[TB] %s acc=%0d rdy=%02h out_valid=%02h data=%02h cnt=%0d",
             tag, acc, rdy, bus.out_valid, bus.out_data, bus.xfer_cnt);
  endtask

  initial begin
    m_reset();
    drive(0, 0, 0, 8'h00, 8'h00);
    bus_w.in_valid = 1'b0; bus_w.in_sel = 3'd0; bus_w.in_bcast = 1'b0;
    bus_w.in_data = 8'h00; bus_w.out_ready = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_outputs("reset");
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_valid_const", 32'(bus.out_valid), 32'h00);

    // Unicast with the sink already ready.
    drive(1, 3, 0, 8'hA5, 8'h08);
    cycle("uni_acc");
    chk("uni.out_valid_const", 32'(bus.out_valid), 32'h08);
    drive(0, 0, 0, 8'h00, 8'h08);
    cycle("uni_drain");
    chk("uni.cnt_const", 32'(bus.xfer_cnt), 32'd1);

    // Unicast under backpressure; in_data wiggles while nothing is offered.
    drive(1, 6, 0, 8'h3C, 8'h00);
    cycle("bp_acc");
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 8'($urandom), 8'h00);
      cycle("bp_hold");
      chk("bp.out_valid_const", 32'(bus.out_valid), 32'h40);
      chk("bp.out_data_const", 32'(bus.out_data), 32'h3C);
    end
    drive(0, 0, 0, 8'h00, 8'h40);
    cycle("bp_drain");
    chk("bp.cnt_const", 32'(bus.xfer_cnt), 32'd2);

    // Broadcast drained in three partial steps.
    drive(1, 2, 1, 8'h7E, 8'h00);
    cycle("bc_acc");
    chk("bc.out_valid_ff", 32'(bus.out_valid), 32'hFF);
    drive(0, 0, 0, 8'h00, 8'h0F);
    cycle("bc_p1");
    chk("bc.p1_const", 32'(bus.out_valid), 32'hF0);
    drive(0, 0, 0, 8'h00, 8'h30);
    cycle("bc_p2");
    chk("bc.p2_cnt_const", 32'(bus.xfer_cnt), 32'd2);
    drive(0, 0, 0, 8'h00, 8'hC0);
    cycle("bc_p3");
    chk("bc.p3_cnt_const", 32'(bus.xfer_cnt), 32'd3);

    // Back-to-back: final drain and new accept share one edge.
    drive(1, 1, 0, 8'h55, 8'h00);
    cycle("b2b_w1");
    drive(1, 2, 0, 8'h11, 8'h02);
    cycle("b2b_w2");
    chk("b2b.out_valid_const", 32'(bus.out_valid), 32'h04);
    chk("b2b.cnt_const", 32'(bus.xfer_cnt), 32'd4);
    drive(0, 0, 0, 8'h00, 8'h04);
    cycle("b2b_drain");

    // Broadcast with every sink ready finishes in one cycle.
    drive(1, 0, 1, 8'hC3, 8'hFF);
    cycle("bcfast_acc");
    drive(0, 0, 0, 8'h00, 8'hFF);
    cycle("bcfast_drain");

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom | $urandom));
      cycle("rand");
    end

    // Reset in the middle of a held word.
    drive(1, 5, 0, 8'h99, 8'h00);
    cycle("mid_acc");
    drive(0, 0, 0, 8'h00, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'h00);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    check_outputs("midrst_release");

    // Counter wrap on the 4-bit instance: one completion per edge after the first.
    bus_w.in_valid = 1'b1; bus_w.in_bcast = 1'b1; bus_w.out_ready = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("wrap.in_ready", 32'(bus_w.in_ready), 32'd1);
      @(posedge clk);
      bus_w.in_data = 8'(k);
    end
    #1;
    chk("wrap.cnt_max", 32'(bus_w.xfer_cnt), 32'hF);
    @(posedge clk);
    #1;
    chk("wrap.cnt_zero", 32'(bus_w.xfer_cnt), 32'h0);
    $display("[TB] wrap cnt=%0d", bus_w.xfer_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1to8_dist.md
Name: demux_1to8_dist

Overview:
Registered 1-to-8 result distributor for the 8-bit ALU datapath; the write-side counterpart of the 8-to-1 operand select mux. It accepts one result word plus a 3-bit destination select, or a broadcast flag. It holds the word and presents it to the selected sink(s) with per-sink valid/ready handshakes. A new word is accepted only once every targeted sink has taken the current one.

Parameters:
WIDTH, 8, data word width in bits.
NUM_OUT, 8, number of destination sinks; fixed at 8 to match the 3-bit select.
CNT_W, 16, width of the completed-transfer counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream word valid.
in_ready  output  1  distributor can accept a word this cycle.
in_sel  input  3  destination index 0..7; ignored when in_bcast=1.
in_bcast  input  1  deliver the word to all 8 sinks.
in_data  input  WIDTH  word to distribute.
out_valid  output  NUM_OUT  per-sink valid; bit i targets sink i.
out_ready  input  NUM_OUT  per-sink ready.
out_data  output  WIDTH  held word; shared by all sinks.
busy  output  1  a word is held with at least one sink still pending.
xfer_cnt  output  CNT_W  number of fully delivered words; wraps.

Behaviour:
- Reset (async assert, sync release): pending mask = 0, out_data = 0, xfer_cnt = 0, state IDLE. Outputs after reset: out_valid = 0, busy = 0, in_ready = 1.
- Reset asserted mid-transfer drops the held word. pending clears immediately and xfer_cnt is not incremented.
- States:
  - IDLE: pending == 0.
  - HOLD: pending != 0.
- Internal signal remain = pending & ~out_ready.
- in_ready = (pending == 0) | (remain == 0). This is combinational from out_ready, which allows back-to-back words with no bubble.
- Accept = in_valid & in_ready.
- On accept at edge N:
  - out_data <= in_data.
  - pending <= in_bcast ? 8'hFF : onehot(in_sel).
  - out_valid reflects the new mask from cycle N+1. Latency is 1 cycle input to output.
- Every edge with no accept: pending <= remain. Sink i completes when out_valid[i] & out_ready[i].
- A ready sink clears its own bit only. Other sinks keep valid, and out_data is stable while any bit is pending.
- out_valid = pending (registered). busy = (pending != 0).
- xfer_cnt increments by 1 on the edge where pending != 0 and remain == 0. This covers the last targeted sink(s) accepting, including the same edge on which a new word is accepted. It wraps from 2^CNT_W-1 to 0.
- Simultaneous final-drain and new accept: the counter increments for the old word, and pending loads the new mask. No idle cycle occurs.
- out_ready on non-pending sinks is ignored.
- in_sel and in_bcast are sampled only on accept.
- in_valid while in_ready=0: no state change. Upstream must hold the word stable.
- Broadcast with all 8 sinks ready on the first cycle completes in one cycle.

Decomposition:
- Shared package alu_pkg: WIDTH, NUM_OUT, SEL_W=3, CNT_W constants, and a onehot8 function.
- One natural sub-module: decoder_3to8. It is the combinational one-hot decoder of in_sel with an enable input, with broadcast ORed in by the parent.
- The pending register, state, and counter live in the top module.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> out_valid=8'h00, in_ready=1, busy=0, xfer_cnt=0, out_data=0.
- Unicast, sink ready: in_sel=3, in_data=8'hA5, out_ready=8'h08 -> out_valid=8'h08 one cycle after accept, out_data=8'hA5. Next edge: out_valid=0, xfer_cnt=1.
- Unicast backpressure: in_sel=6, data=8'h3C, out_ready=0 for 4 cycles -> out_valid=8'h40 held 4 cycles, in_ready=0, data stable. Raise out_ready[6] -> delivered, xfer_cnt+1.
- Broadcast partial drain: in_bcast=1, data=8'h7E. Drive out_ready 8'h0F, then 8'h30, then 8'hC0 -> pending 8'hF0, 8'hC0, 8'h00. xfer_cnt increments only on the third edge.
- Back-to-back: word1 sel=1, sink1 ready in the same cycle word2 (sel=2, 8'h11) is offered -> in_ready=1, no bubble, out_valid=8'h04 next cycle, xfer_cnt+1.
- Mid-transfer reset plus counter wrap: reset during HOLD -> out_valid=0 asynchronously, xfer_cnt=0. Separately, preload 16'hFFFF worth of completions -> the next completion gives xfer_cnt=0.
